// File: rtl/clink_frame_packer.sv
// rtl/clink_frame_packer.sv - Camera Link pixel qualifier and AXI4-Stream beat packer
module clink_frame_packer #(
  parameter int PIX_WIDTH      = 8,
  parameter int IN_PIX         = 2,
  parameter int OUT_DATA_WIDTH = 128,
  parameter int LINE_CNT_WIDTH = 16
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cfg_enable,
  input  logic [LINE_CNT_WIDTH-1:0]     cfg_line_pixels,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_WIDTH*IN_PIX-1:0]   in_data,
  input  logic                          in_fval,
  input  logic                          in_lval,
  input  logic                          in_dval,
  output logic [OUT_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [OUT_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [31:0]                   frame_count,
  output logic                          err_short_line,
  output logic                          err_long_line
);

  localparam int WORD_W = PIX_WIDTH * IN_PIX;
  localparam int WORDS  = OUT_DATA_WIDTH / WORD_W;
  localparam int KEEP_W = OUT_DATA_WIDTH / 8;
  localparam int WB     = WORD_W / 8;
  localparam int CNT_W  = $clog2(WORDS + 1);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_LINE, IN_LINE, DISCARD} state_t;

  state_t                    state;
  state_t                    frame_done_state;
  logic [OUT_DATA_WIDTH-1:0] acc_data;
  logic [OUT_DATA_WIDTH-1:0] merged;
  logic [CNT_W-1:0]          acc_cnt;
  logic [LINE_CNT_WIDTH-1:0] pix_cnt;
  logic [LINE_CNT_WIDTH-1:0] pix_base;
  logic [LINE_CNT_WIDTH-1:0] pix_next;
  logic [LINE_CNT_WIDTH-1:0] line_len;
  logic                      sof_pending;
  logic                      sof_take;
  logic                      long_seen;
  logic                      consumed;
  logic                      line_start;
  logic                      line_end;
  logic                      accept;
  logic                      acc_full;
  logic                      len_hit;

  function automatic logic [KEEP_W-1:0] keep_for(input logic [CNT_W-1:0] n);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < WORDS; i++)
      if (CNT_W'(i) < n) k[i*WB +: WB] = '1;
    return k;
  endfunction

  assign in_ready   = ~m_axis_tvalid | m_axis_tready;
  assign consumed   = in_valid & in_ready;
  assign line_start = consumed & (state == WAIT_LINE) & in_fval & in_lval;
  assign accept     = consumed & in_fval & in_lval & in_dval & ((state == IN_LINE) | line_start);
  assign line_end   = consumed & (state == IN_LINE) & (~in_lval | ~in_fval);
  assign pix_base   = line_start ? '0 : pix_cnt;
  assign pix_next   = pix_base + LINE_CNT_WIDTH'(IN_PIX);
  assign len_hit    = pix_next >= line_len;
  assign acc_full   = acc_cnt == CNT_W'(WORDS - 1);
  assign frame_done_state = cfg_enable ? ARMED : IDLE;
  // A tuser beat leaving this cycle has already used up the pending start-of-frame.
  assign sof_take   = sof_pending & ~(m_axis_tvalid & m_axis_tready & m_axis_tuser);

  always_comb begin
    merged = acc_data;
    for (int i = 0; i < WORDS; i++)
      if (acc_cnt == CNT_W'(i)) merged[i*WORD_W +: WORD_W] = in_data;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state          <= IDLE;
      acc_data       <= '0;
      acc_cnt        <= '0;
      pix_cnt        <= '0;
      line_len       <= '0;
      sof_pending    <= 1'b0;
      long_seen      <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      frame_count    <= '0;
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
    end else begin
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tuser) sof_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (consumed && !in_fval && cfg_enable) state <= ARMED;
        end
        ARMED: begin
          if (consumed && in_fval) begin
            line_len    <= cfg_line_pixels;
            sof_pending <= 1'b1;
            state       <= WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (consumed) begin
            if (!in_fval) begin
              frame_count <= frame_count + 32'd1;
              state       <= frame_done_state;
            end else if (in_lval) begin
              pix_cnt <= '0;
              state   <= IN_LINE;
            end
          end
        end
        IN_LINE: begin
          if (line_end) begin
            m_axis_tdata   <= acc_data;
            m_axis_tkeep   <= keep_for(acc_cnt);
            m_axis_tvalid  <= 1'b1;
            m_axis_tlast   <= 1'b1;
            m_axis_tuser   <= sof_take;
            acc_data       <= '0;
            acc_cnt        <= '0;
            err_short_line <= 1'b1;
            if (!in_fval) begin
              frame_count <= frame_count + 32'd1;
              state       <= frame_done_state;
            end else begin
              state <= WAIT_LINE;
            end
          end
        end
        DISCARD: begin
          if (consumed) begin
            if (in_fval && in_lval && in_dval && !long_seen) begin
              err_long_line <= 1'b1;
              long_seen     <= 1'b1;
            end
            if (!in_fval || !in_lval) state <= WAIT_LINE;
          end
        end
        default: state <= IDLE;
      endcase

      // Pixel append also covers the first word of a line, taken straight from WAIT_LINE.
      if (accept) begin
        pix_cnt <= pix_next;
        if (acc_full || len_hit) begin
          m_axis_tdata  <= merged;
          m_axis_tkeep  <= keep_for(acc_cnt + 1'b1);
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= len_hit;
          m_axis_tuser  <= sof_take;
          acc_data      <= '0;
          acc_cnt       <= '0;
        end else begin
          acc_data <= merged;
          acc_cnt  <= acc_cnt + 1'b1;
        end
        if (len_hit) begin
          state     <= DISCARD;
          long_seen <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clink_frame_packer.sv
// tb/tb_clink_frame_packer.sv - directed table-driven bench for clink_frame_packer
module tb_clink_frame_packer;

  logic         s_axi_aclk = 1'b0;
  logic         s_axi_aresetn = 1'b0;
  logic         cfg_enable = 1'b0;
  logic [15:0]  cfg_line_pixels = 16'd16;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = '0;
  logic         in_fval = 1'b0;
  logic         in_lval = 1'b0;
  logic         in_dval = 1'b0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic [31:0]  frame_count;
  logic         err_short_line;
  logic         err_long_line;

  clink_frame_packer dut (
    .s_axi_aclk      (s_axi_aclk),
    .s_axi_aresetn   (s_axi_aresetn),
    .cfg_enable      (cfg_enable),
    .cfg_line_pixels (cfg_line_pixels),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_fval         (in_fval),
    .in_lval         (in_lval),
    .in_dval         (in_dval),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .frame_count     (frame_count),
    .err_short_line  (err_short_line),
    .err_long_line   (err_long_line)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  typedef struct {
    int          cfg;
    int          sent;
    int          lines;
    int          beats;
    logic [15:0] last_keep;
    int          shrt;
    int          lng;
    int          mode;
    bit          en;
    bit          capt;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  beat_t        rx_q[$];
  vec_t         tbl[11];
  int           n_vec = 0;
  int           n_bad = 0;
  int           n_short = 0;
  int           n_long = 0;
  int           exp_fc = 0;
  int           tready_mode = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [17:0]  prev_ctl;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic send(input logic f, input logic l, input logic d, input logic [15:0] w);
    int t;
    t = 0;
    in_valid = 1'b1; in_fval = f; in_lval = l; in_dval = d; in_data = w;
    forever begin
      @(negedge s_axi_aclk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_vec++; n_bad++;
        $display("FAIL send_timeout: in_ready stuck low for %0d cycles", t);
        break;
      end
    end
    @(posedge s_axi_aclk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge s_axi_aclk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Collects transferred beats and checks AXIS hold rules under back-pressure.
  initial begin
    forever begin
      @(negedge s_axi_aclk);
      if (s_axi_aresetn) begin
        if (m_axis_tvalid && m_axis_tready)
          rx_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        if (err_short_line) n_short++;
        if (err_long_line) n_long++;
        if (m_axis_tvalid && !m_axis_tready) chk("in_ready_stall", 128'(in_ready), 128'(0));
        if (prev_stall) begin
          chk("stall_tvalid", 128'(m_axis_tvalid), 128'(1));
          chk("stall_tdata", m_axis_tdata, prev_data);
          chk("stall_ctl", 128'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 128'(prev_ctl));
        end
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready & s_axi_aresetn;
      prev_data  = m_axis_tdata;
      prev_ctl   = {m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_frame(input vec_t v, input logic [7:0] base);
    logic [7:0]   p;
    logic [127:0] ed;
    logic [15:0]  ek;
    int           nb;
    int           idx;
    rx_q.delete(); n_short = 0; n_long = 0;
    cfg_enable = v.en; cfg_line_pixels = 16'(v.cfg); tready_mode = v.mode;
    send(0, 0, 0, 16'h0); send(0, 0, 0, 16'h0); send(1, 0, 0, 16'h0);
    p = base;
    for (int l = 0; l < v.lines; l++) begin
      send(1, 1, 0, 16'hDEAD);
      for (int i = 0; i < v.sent / 2; i++) begin
        send(1, 1, 1, {p + 8'd1, p});
        p = p + 8'd2;
      end
      send(1, 0, 0, 16'h0);
    end
    send(0, 0, 0, 16'h0); send(0, 0, 0, 16'h0);
    idle(8);
    tready_mode = 0;
    idle(2);
    if (v.capt) exp_fc++;
    chk("beat_count", 128'(rx_q.size()), 128'(v.capt ? v.lines * v.beats : 0));
    chk("err_short_pulses", 128'(n_short), 128'(v.capt ? v.shrt * v.lines : 0));
    chk("err_long_pulses", 128'(n_long), 128'(v.capt ? v.lng * v.lines : 0));
    chk("frame_count", 128'(frame_count), 128'(exp_fc));
    if (v.capt) begin
      for (int l = 0; l < v.lines; l++) begin
        for (int b = 0; b < v.beats; b++) begin
          idx = l * v.beats + b;
          if (idx < rx_q.size()) begin
            ek = (b == v.beats - 1) ? v.last_keep : 16'hFFFF;
            nb = $countones(ek);
            ed = '0;
            for (int j = 0; j < nb; j++)
              ed[j*8 +: 8] = 8'(int'(base) + l * v.sent + b * 16 + j);
            chk("beat_tdata", rx_q[idx].d, ed);
            chk("beat_tkeep", 128'(rx_q[idx].k), 128'(ek));
            chk("beat_tlast", 128'(rx_q[idx].l), 128'(b == v.beats - 1));
            chk("beat_tuser", 128'(rx_q[idx].u), 128'(l == 0 && b == 0));
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] p;
    //            cfg sent ln bt keep      sh lg md en capt
    tbl[0]  = '{16, 16, 1, 1, 16'hFFFF, 0, 0, 0, 1'b1, 1'b1};
    tbl[1]  = '{20, 20, 2, 2, 16'h000F, 0, 0, 0, 1'b1, 1'b1};
    tbl[2]  = '{16,  6, 1, 1, 16'h003F, 1, 0, 0, 1'b1, 1'b1};
    tbl[3]  = '{16, 20, 1, 1, 16'hFFFF, 0, 1, 0, 1'b1, 1'b1};
    tbl[4]  = '{ 2,  2, 1, 1, 16'h0003, 0, 0, 0, 1'b1, 1'b1};
    tbl[5]  = '{16,  0, 1, 1, 16'h0000, 1, 0, 0, 1'b1, 1'b1};
    tbl[6]  = '{32, 16, 1, 2, 16'h0000, 1, 0, 0, 1'b1, 1'b1};
    tbl[7]  = '{64, 64, 2, 4, 16'hFFFF, 0, 0, 1, 1'b1, 1'b1};
    tbl[8]  = '{16, 16, 1, 1, 16'hFFFF, 0, 0, 0, 1'b0, 1'b1};
    tbl[9]  = '{16, 16, 1, 1, 16'hFFFF, 0, 0, 0, 1'b0, 1'b0};
    tbl[10] = '{16, 16, 1, 1, 16'hFFFF, 0, 0, 0, 1'b1, 1'b1};

    idle(3);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tdata", m_axis_tdata, 128'(0));
    chk("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
    chk("rst_tlast_tuser", 128'({m_axis_tlast, m_axis_tuser}), 128'(0));
    chk("rst_errs", 128'({err_short_line, err_long_line}), 128'(0));
    chk("rst_frame_count", 128'(frame_count), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    s_axi_aresetn = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) run_frame(tbl[i], 8'(i * 16));

    // Reset while a beat is held, then enable mid-frame: nothing until the next frame start.
    tready_mode = 2; cfg_enable = 1'b1; cfg_line_pixels = 16'd32;
    idle(2);
    send(0, 0, 0, 16'h0); send(1, 0, 0, 16'h0); send(1, 1, 0, 16'hDEAD);
    p = 8'h40;
    for (int i = 0; i < 8; i++) begin send(1, 1, 1, {p + 8'd1, p}); p = p + 8'd2; end
    idle(1);
    chk("held_tvalid", 128'(m_axis_tvalid), 128'(1));
    s_axi_aresetn = 1'b0;
    idle(2);
    chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("midrst_tdata", m_axis_tdata, 128'(0));
    chk("midrst_ctl", 128'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 128'(0));
    chk("midrst_frame_count", 128'(frame_count), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    s_axi_aresetn = 1'b1; tready_mode = 0; exp_fc = 0;
    idle(2);
    rx_q.delete();
    for (int i = 0; i < 8; i++) begin send(1, 1, 1, {p + 8'd1, p}); p = p + 8'd2; end
    send(1, 0, 0, 16'h0); send(1, 1, 1, 16'h5555); send(1, 0, 0, 16'h0);
    idle(4);
    chk("midframe_no_beats", 128'(rx_q.size()), 128'(0));
    run_frame(tbl[0], 8'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
